pe_array_seq: RTL and testbench
===============================

Name: pe_array_seq

Overview:
- Sequencer that feeds the binarized PE array for one output tile.
- Pulls weight and activation words from two valid/ready sources and emits the interleaved 27-bit stream the PE array consumes: per column group, O_CH weight words, then 1 activation word.
- After the stream it waits out the array pipeline, captures the O_CH serialized partial sums into a local buffer, and returns them through a valid/ready result port.
- Sits between the on-chip weight/activation buffers and the PE array.

Parameters:
- DATA_W, 27, width of one PE input word.
- PSUM_W, 14, partial-sum width.
- ROW_LENGTH, 11, PE row length (column groups per run).
- O_CH, 8, number of PE rows (output channels).
- K, 10, number of runs per tile.
- DRAIN, 3, cycles from last fed word to first valid psum.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, synchronous, active-low.
- start  in  1  tile start pulse; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the tile completes.
- w_data  in  DATA_W  weight word.
- w_valid  in  1  weight word valid.
- w_ready  out  1  weight word accepted when w_valid&w_ready.
- a_data  in  DATA_W  activation word.
- a_valid  in  1  activation word valid.
- a_ready  out  1  activation word accepted when a_valid&a_ready.
- pe_rst_n  out  1  PE array reset, active-low.
- pe_data  out  DATA_W  word to PE array.
- pe_valid  out  1  pe_data is live; the array wrapper advances only when high.
- psum_in  in  PSUM_W  serialized psum from the PE array.
- res_data  out  PSUM_W  result word.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_last  out  1  high with the row O_CH-1 result.

Behaviour:
- Reset (rst_in low at a clock edge):
  - State goes to IDLE.
  - busy, done, pe_valid, res_valid, res_last = 0; pe_data = 0; pe_rst_n = 0.
  - All counters and the buffer occupancy are cleared.
  - Reset mid-operation aborts the tile with no further output.
  - pe_rst_n goes to 1 on the first edge after rst_in returns high.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> COLLECT -> FLUSH -> IDLE.
- IDLE:
  - start=1 -> CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - pe_rst_n = 0 for exactly 2 cycles, then FEED.
  - pe_rst_n = 1 in every other non-reset state.
- FEED:
  - Slot counter s runs 0..O_CH; group counter g runs 0..ROW_LENGTH*K-1.
  - w_ready = (s<O_CH); a_ready = (s==O_CH). Both are combinational from state/s and are 0 outside FEED.
  - On a handshake, the word is registered to pe_data with pe_valid=1 at the next edge (latency 1 cycle), and s increments.
  - s wraps O_CH->0 with g+1.
  - No handshake -> pe_valid=0 next cycle, pe_data holds its last value.
  - A stalled source never lets the other source advance; order is strict.
  - Accepting the activation at s==O_CH, g==ROW_LENGTH*K-1 -> DRAIN. Total = (O_CH+1)*ROW_LENGTH*K words (990 at defaults).
- DRAIN / COLLECT:
  - Let L be the cycle where the last pe_valid is high.
  - psum_in for row r is sampled at cycle L+DRAIN+r, r = 0..O_CH-1, into buffer entry r.
  - pe_valid = 0 throughout.
  - After row O_CH-1 is captured -> FLUSH.
- Result port:
  - The buffer is an O_CH-deep FIFO; it never overflows because the capture count equals the depth.
  - res_valid = buffer non-empty; it may assert during COLLECT.
  - res_data = oldest entry. It pops on res_valid&res_ready.
  - While res_valid=1 and res_ready=0, res_data and res_last are stable.
  - res_last = 1 with the row O_CH-1 entry.
- FLUSH:
  - When the res_last entry handshakes, done=1 for that next cycle and state goes to IDLE (busy=0 in the same cycle as done).
  - Capture and pop in the same cycle are both honoured.
- Arithmetic: psums are passed through unmodified, with no sign extension or saturation.

Test Plan:
- Defaults, both sources always valid, res_ready=1, start pulse:
  - pe_rst_n low 2 cycles.
  - pe_valid high 990 consecutive cycles in the pattern 8 weights, 1 activation.
  - psum sampled at L+3..L+10.
  - 8 results in row order, res_last on the 8th.
  - done pulse, then busy=0.
- Hold a_valid=0 for 5 cycles at g=0, s=8:
  - pe_valid=0 and w_ready=0 for those 5 cycles; no weight consumed.
  - The stream resumes with that activation.
- res_ready=0 from start through COLLECT:
  - All 8 psums buffered.
  - After res_ready=1, 8 beats in order with no loss; done follows the last beat.
- start asserted every cycle while busy:
  - Exactly one tile executes and CLEAR happens once.
  - Word count is still 990.
- rst_in low for 1 cycle at g=50:
  - All outputs at reset values the next cycle.
  - A new start restarts from g=0, s=0 with a full 990-word stream.
- Override ROW_LENGTH=2, K=1, O_CH=2, DRAIN=3:
  - 6 words in the order w,w,a,w,w,a.
  - 2 results, res_last on the 2nd.

Source files
------------

// File: rtl/pe_array_seq.sv
// pe_array_seq: sequencer feeding the binarized PE array for one output tile.
// Streams O_CH weight words then one activation word per column group, waits
// out the array pipeline, buffers the O_CH serialized partial sums and hands
// them back through a valid/ready result port.
module pe_array_seq #(
  parameter int DATA_W     = 27,
  parameter int PSUM_W     = 14,
  parameter int ROW_LENGTH = 11,
  parameter int O_CH       = 8,
  parameter int K          = 10,
  parameter int DRAIN      = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  output logic              pe_rst_n,
  output logic [DATA_W-1:0] pe_data,
  output logic              pe_valid,
  input  logic [PSUM_W-1:0] psum_in,
  output logic [PSUM_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last
);

  // Counter widths. The drain counter counts 0..DRAIN-1 (DRAIN must be >= 1).
  localparam int GROUPS = ROW_LENGTH * K;
  localparam int SW     = $clog2(O_CH + 1);
  localparam int GW     = $clog2(GROUPS + 1);
  localparam int PW     = (O_CH > 1) ? $clog2(O_CH) : 1;
  localparam int CW     = $clog2(O_CH + 1);
  localparam int DW     = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  localparam logic [SW-1:0] S_ACT      = SW'(O_CH);
  localparam logic [GW-1:0] G_LAST     = GW'(GROUPS - 1);
  localparam logic [PW-1:0] ROW_LAST   = PW'(O_CH - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_COLLECT,
    ST_FLUSH
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              clr_cnt_reg;
  logic [SW-1:0]     s_reg;
  logic [GW-1:0]     g_reg;
  logic [DW-1:0]     d_reg;
  logic [DATA_W-1:0] pe_data_reg;
  logic              pe_valid_reg;
  logic              pe_rst_n_reg;
  logic              done_reg;
  logic [PSUM_W-1:0] buf_mem [0:O_CH-1];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  logic w_fire;
  logic a_fire;
  logic feed_fire;
  logic capture;
  logic pop;
  logic last_pop;

  // Source handshakes: strict slot order, weights for s<O_CH, activation at s==O_CH.
  assign w_ready   = (state_reg == ST_FEED) && (s_reg != S_ACT);
  assign a_ready   = (state_reg == ST_FEED) && (s_reg == S_ACT);
  assign w_fire    = w_valid && w_ready;
  assign a_fire    = a_valid && a_ready;
  assign feed_fire = w_fire || a_fire;

  // One psum row is captured every COLLECT cycle; wr_ptr doubles as the row index.
  assign capture   = (state_reg == ST_COLLECT);
  assign res_valid = (count_reg != '0);
  assign res_data  = buf_mem[rd_ptr_reg];
  assign res_last  = res_valid && (rd_ptr_reg == ROW_LAST);
  assign pop       = res_valid && res_ready;
  assign last_pop  = pop && res_last;

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign pe_rst_n = pe_rst_n_reg;
  assign pe_data  = pe_data_reg;
  assign pe_valid = pe_valid_reg;

  // Next-state logic for the tile sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_CLEAR;
      ST_CLEAR:   if (clr_cnt_reg) state_next = ST_FEED;
      ST_FEED:    if (a_fire && (g_reg == G_LAST)) state_next = ST_DRAIN;
      ST_DRAIN:   if (d_reg == DRAIN_LAST) state_next = ST_COLLECT;
      ST_COLLECT: if (wr_ptr_reg == ROW_LAST) state_next = ST_FLUSH;
      ST_FLUSH:   if (last_pop) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // CLEAR lasts two cycles: this bit marks the second one.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      clr_cnt_reg <= 1'b0;
    end else begin
      clr_cnt_reg <= (state_reg == ST_CLEAR) ? ~clr_cnt_reg : 1'b0;
    end
  end

  // Slot (s) and column-group (g) counters advance only on accepted words.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s_reg <= '0;
      g_reg <= '0;
    end else if (state_reg != ST_FEED) begin
      s_reg <= '0;
      g_reg <= '0;
    end else if (a_fire) begin
      s_reg <= '0;
      g_reg <= (g_reg == G_LAST) ? '0 : g_reg + GW'(1);
    end else if (w_fire) begin
      s_reg <= s_reg + SW'(1);
    end
  end

  // Drain counter: the cycle after the last fed word is observed counts as 0,
  // so row 0 is captured DRAIN cycles after the last live pe_valid.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      d_reg <= '0;
    end else if (state_reg == ST_DRAIN) begin
      d_reg <= d_reg + DW'(1);
    end else begin
      d_reg <= '0;
    end
  end

  // PE word register: one-cycle latency from handshake; data holds when idle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pe_data_reg  <= '0;
      pe_valid_reg <= 1'b0;
    end else begin
      pe_valid_reg <= feed_fire;
      if (feed_fire) begin
        pe_data_reg <= a_fire ? a_data : w_data;
      end
    end
  end

  // PE array reset follows CLEAR exactly, and is held low through our own reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pe_rst_n_reg <= 1'b0;
    end else begin
      pe_rst_n_reg <= (state_next != ST_CLEAR);
    end
  end

  // Completion pulse in the cycle after the final result handshake.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == ST_FLUSH) && last_pop;
    end
  end

  // Result buffer storage; validity is tracked by the occupancy count alone.
  always_ff @(posedge clk_in) begin
    if (capture) begin
      buf_mem[wr_ptr_reg] <= psum_in;
    end
  end

  // Buffer pointers and occupancy; capture and pop in one cycle both apply.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (capture) begin
        wr_ptr_reg <= (wr_ptr_reg == ROW_LAST) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == ROW_LAST) ? '0 : rd_ptr_reg + PW'(1);
      end
      if (capture && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (!capture && pop) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_array_seq.sv
// Bench for pe_array_seq: scenario table for full tiles at default parameters,
// plus hand-written sequences for mid-tile reset and a small configuration.
module tb_pe_array_seq;

  localparam int DATA_W = 27;
  localparam int PSUM_W = 14;
  localparam int O_CH   = 8;
  localparam int ROWL   = 11;
  localparam int KK     = 10;
  localparam int DRAIN  = 3;
  localparam int TOTAL  = (O_CH + 1) * ROWL * KK;

  typedef struct {
    int a_stall;
    bit res_hold;
    bit spam;
    int exp_words;
    int exp_clear;
    int exp_run;
    int exp_res;
  } scen_t;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [DATA_W-1:0] w_data, a_data;
  logic              w_valid = 1'b0, a_valid = 1'b0;
  logic              w_ready, a_ready;
  logic              pe_rst_n, pe_valid;
  logic [DATA_W-1:0] pe_data;
  logic [PSUM_W-1:0] psum_in;
  logic [PSUM_W-1:0] res_data;
  logic              res_valid, res_last;
  logic              res_ready = 1'b0;

  logic              b_start = 1'b0;
  logic              b_busy, b_done;
  logic [DATA_W-1:0] b_w_data, b_a_data;
  logic              b_w_valid = 1'b0, b_a_valid = 1'b0;
  logic              b_w_ready, b_a_ready;
  logic              b_pe_rst_n, b_pe_valid;
  logic [DATA_W-1:0] b_pe_data;
  logic [PSUM_W-1:0] b_res_data;
  logic              b_res_valid, b_res_last;
  logic              b_res_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int w_idx = 0, a_idx = 0, b_w_idx = 0, b_a_idx = 0;
  int n_acc = 0, n_res = 0;

  logic [DATA_W-1:0] exp_pe [$];
  logic [PSUM_W-1:0] exp_res [$];
  bit                hs_prev = 1'b0;
  bit                hs_w, hs_a;
  int                n_hs_t = 0, n_pe_t = 0;
  bit                stall_prev = 1'b0;
  logic [PSUM_W-1:0] prev_data;
  logic              prev_last;

  scen_t             tbl [4];
  logic [DATA_W-1:0] b_exp [6];

  function automatic logic [PSUM_W-1:0] stamp(input int c);
    return PSUM_W'(c * 37 + 5);
  endfunction

  assign psum_in  = stamp(cyc);
  assign w_data   = {1'b0, 26'(w_idx * 7 + 3)};
  assign a_data   = {1'b1, 26'(a_idx * 11 + 1)};
  assign b_w_data = {1'b0, 26'(b_w_idx)};
  assign b_a_data = {1'b1, 26'(b_a_idx)};

  always #5 clk_in = ~clk_in;

  pe_array_seq dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .busy(busy), .done(done),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .pe_rst_n(pe_rst_n), .pe_data(pe_data), .pe_valid(pe_valid),
    .psum_in(psum_in), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_last(res_last)
  );

  pe_array_seq #(.ROW_LENGTH(2), .K(1), .O_CH(2), .DRAIN(3)) dut_small (
    .clk_in(clk_in), .rst_in(rst_in), .start(b_start), .busy(b_busy), .done(b_done),
    .w_data(b_w_data), .w_valid(b_w_valid), .w_ready(b_w_ready),
    .a_data(b_a_data), .a_valid(b_a_valid), .a_ready(b_a_ready),
    .pe_rst_n(b_pe_rst_n), .pe_data(b_pe_data), .pe_valid(b_pe_valid),
    .psum_in(psum_in), .res_data(b_res_data), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .res_last(b_res_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source index and handshake counters, advanced on the clock edge.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (rst_in) begin
      if (w_valid && w_ready) begin w_idx <= w_idx + 1; n_acc <= n_acc + 1; end
      if (a_valid && a_ready) begin a_idx <= a_idx + 1; n_acc <= n_acc + 1; end
      if (res_valid && res_ready) n_res <= n_res + 1;
      if (b_w_valid && b_w_ready) b_w_idx <= b_w_idx + 1;
      if (b_a_valid && b_a_ready) b_a_idx <= b_a_idx + 1;
    end
  end

  // Scoreboard for the default instance: words in order, latency, psum timing.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      exp_pe.delete();
      exp_res.delete();
      hs_prev = 1'b0;
      stall_prev = 1'b0;
      n_hs_t = 0;
      n_pe_t = 0;
    end else begin
      check("pe_latency", pe_valid, hs_prev);
      if (pe_valid) begin
        if (exp_pe.size() == 0) check("pe_unexpected", pe_valid, 0);
        else check("pe_data", pe_data, exp_pe.pop_front());
        n_pe_t++;
        if (n_pe_t == TOTAL)
          for (int r = 0; r < O_CH; r++) exp_res.push_back(stamp(cyc + DRAIN + r));
      end
      hs_w = w_valid && w_ready;
      hs_a = a_valid && a_ready;
      if (hs_w || hs_a) begin
        check("slot_kind", hs_a, (n_hs_t % (O_CH + 1)) == O_CH);
        exp_pe.push_back(hs_a ? a_data : w_data);
        n_hs_t++;
      end
      hs_prev = hs_w || hs_a;
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) check("res_unexpected", res_valid, 0);
        else begin
          check("res_data", res_data, exp_res.pop_front());
          check("res_last", res_last, exp_res.size() == 0);
        end
      end
      if (stall_prev) begin
        check("res_hold_valid", res_valid, 1);
        check("res_hold_data", res_data, prev_data);
        check("res_hold_last", res_last, prev_last);
      end
      stall_prev = res_valid && !res_ready;
      prev_data = res_data;
      prev_last = res_last;
      if (!busy) begin
        n_hs_t = 0;
        n_pe_t = 0;
      end
    end
  end

  task automatic run_tile(input scen_t sc, input string tag);
    int  acc0, res0, pe_cnt, clr_cnt, run, max_run, stall_cnt, hold_wait;
    bit  got_done;
    acc0 = n_acc; res0 = n_res;
    pe_cnt = 0; clr_cnt = 0; run = 0; max_run = 0; stall_cnt = 0; hold_wait = -1;
    got_done = 1'b0;
    w_valid = 1'b1;
    a_valid = (sc.a_stall == 0);
    res_ready = !sc.res_hold;
    start = 1'b1;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(posedge clk_in); #1;
      start = sc.spam ? busy : 1'b0;
      if (i == 0) check({tag, "_busy_after_start"}, busy, 1);
      if (!pe_rst_n) clr_cnt++;
      if (pe_valid) begin
        pe_cnt++; run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (sc.a_stall > 0 && !a_valid) begin
        if (stall_cnt == sc.a_stall) a_valid = 1'b1;
        else if (a_ready) begin
          check("stall_w_ready", w_ready, 0);
          if (stall_cnt > 0) check("stall_pe_valid", pe_valid, 0);
          stall_cnt++;
        end
      end
      if (sc.res_hold && !res_ready) begin
        if (pe_cnt == TOTAL && hold_wait < 0) hold_wait = 12;
        if (hold_wait == 0) begin
          check("held_res_valid", res_valid, 1);
          check("held_no_pops", n_res - res0, 0);
          res_ready = 1'b1;
        end else if (hold_wait > 0) hold_wait--;
      end
      if (done) begin
        got_done = 1'b1;
        check({tag, "_busy_with_done"}, busy, 0);
      end
    end
    check({tag, "_done_seen"}, got_done, 1);
    check({tag, "_words"}, n_acc - acc0, sc.exp_words);
    check({tag, "_pe_valid_cnt"}, pe_cnt, sc.exp_words);
    check({tag, "_clear_cycles"}, clr_cnt, sc.exp_clear);
    check({tag, "_max_run"}, max_run, sc.exp_run);
    check({tag, "_results"}, n_res - res0, sc.exp_res);
    check({tag, "_pe_queue_empty"}, exp_pe.size(), 0);
    check({tag, "_res_queue_empty"}, exp_res.size(), 0);
    if (sc.a_stall > 0) check({tag, "_stall_cycles"}, stall_cnt, sc.a_stall);
    @(posedge clk_in); #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    $display("tile %s: words=%0d results=%0d clear=%0d run=%0d", tag,
             n_acc - acc0, n_res - res0, clr_cnt, max_run);
    a_valid = 1'b1;
    res_ready = 1'b1;
  endtask

  initial begin
    int acc0, nb, nr, lb;
    bit reached, b_done_seen;

    tbl[0] = '{a_stall: 0, res_hold: 0, spam: 0, exp_words: TOTAL, exp_clear: 2, exp_run: TOTAL,     exp_res: O_CH};
    tbl[1] = '{a_stall: 5, res_hold: 0, spam: 0, exp_words: TOTAL, exp_clear: 2, exp_run: TOTAL - 8, exp_res: O_CH};
    tbl[2] = '{a_stall: 0, res_hold: 1, spam: 0, exp_words: TOTAL, exp_clear: 2, exp_run: TOTAL,     exp_res: O_CH};
    tbl[3] = '{a_stall: 0, res_hold: 0, spam: 1, exp_words: TOTAL, exp_clear: 2, exp_run: TOTAL,     exp_res: O_CH};
    b_exp[0] = {1'b0, 26'd0};
    b_exp[1] = {1'b0, 26'd1};
    b_exp[2] = {1'b1, 26'd0};
    b_exp[3] = {1'b0, 26'd2};
    b_exp[4] = {1'b0, 26'd3};
    b_exp[5] = {1'b1, 26'd1};

    // Reset state.
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pe_valid", pe_valid, 0);
    check("rst_pe_data", pe_data, 0);
    check("rst_pe_rst_n", pe_rst_n, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_last", res_last, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_a_ready", a_ready, 0);
    $display("reset: busy=%0b pe_rst_n=%0b pe_valid=%0b", busy, pe_rst_n, pe_valid);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("rst_release_pe_rst_n", pe_rst_n, 1);

    // Scenario table.
    for (int t = 0; t < 4; t++) run_tile(tbl[t], $sformatf("scen%0d", t));

    // Reset for one cycle at g=50, then a fresh tile.
    start = 1'b1; w_valid = 1'b1; a_valid = 1'b1; res_ready = 1'b1;
    acc0 = n_acc; reached = 1'b0;
    for (int i = 0; i < 1500 && !reached; i++) begin
      @(posedge clk_in); #1;
      start = 1'b0;
      if (n_acc - acc0 >= 50 * (O_CH + 1)) reached = 1'b1;
    end
    check("midrst_reached_g50", reached, 1);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pe_valid", pe_valid, 0);
    check("midrst_pe_data", pe_data, 0);
    check("midrst_pe_rst_n", pe_rst_n, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_last", res_last, 0);
    check("midrst_w_ready", w_ready, 0);
    $display("mid-tile reset after %0d words: busy=%0b pe_valid=%0b", n_acc - acc0, busy, pe_valid);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      check("midrst_quiet", {busy, pe_valid, res_valid, done}, 4'b0);
    end
    run_tile(tbl[0], "after_rst");

    // Small configuration: ROW_LENGTH=2, K=1, O_CH=2, DRAIN=3.
    b_w_valid = 1'b1; b_a_valid = 1'b1; b_res_ready = 1'b1; b_start = 1'b1;
    nb = 0; nr = 0; lb = 0; b_done_seen = 1'b0;
    for (int i = 0; i < 200 && !b_done_seen; i++) begin
      @(posedge clk_in); #1;
      b_start = 1'b0;
      if (b_pe_valid) begin
        if (nb < 6) check($sformatf("small_word%0d", nb), b_pe_data, b_exp[nb]);
        nb++;
        lb = cyc;
      end
      if (b_res_valid) begin
        check($sformatf("small_res%0d", nr), b_res_data, stamp(lb + DRAIN + nr));
        check($sformatf("small_last%0d", nr), b_res_last, nr == 1);
        nr++;
      end
      if (b_done) b_done_seen = 1'b1;
    end
    check("small_done_seen", b_done_seen, 1);
    check("small_words", nb, 6);
    check("small_results", nr, 2);
    check("small_busy_end", b_busy, 0);
    $display("small tile: words=%0d results=%0d", nb, nr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
